dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8'd32: maximum BUSY cycles spent waiting for complete_data before abort.
REQ-002 clock  input  1  single clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester N has a transaction pending.
REQ-005 req0_rd / req1_rd  input  1  1 = read, 0 = write.
REQ-006 req0_addr / req1_addr  input  16  word address.
REQ-007 req0_wdata / req1_wdata  input  16  write data.
REQ-008 req0_ready / req1_ready  output  1  combinational; accept strobe for requester N.
REQ-009 req0_done / req1_done  output  1  registered one-cycle completion pulse.
REQ-010 req0_err / req1_err  output  1  registered one-cycle timeout pulse.
REQ-011 req0_rdata / req1_rdata  output  16  read data; valid in the cycle done is high, held until the next read completes.
REQ-012 data_req  output  1  memory strobe; high for the whole BUSY state.
REQ-013 data_addr  output  16  memory address.
REQ-014 data_din  output  16  write data to memory.
REQ-015 data_rd  output  1  memory read/write select.
REQ-016 data_dout  input  16  read data from memory.
REQ-017 complete_data  input  1  memory completion; sampled only in BUSY.

Function
REQ-018 FSM states are IDLE and BUSY only.
REQ-019 In IDLE, reqN_ready SHALL equal the round-robin pick among asserted valids; at most one ready is high; both readies are low in BUSY.
REQ-020 A transfer occurs on a cycle with valid && ready; on that edge, addr/wdata/rd and the owner ID are latched into data_addr/data_din/data_rd/owner, data_req goes 1, timeout counter clears, state goes BUSY.
REQ-021 Priority: after reset req0 wins a tie; after each completion or timeout, the other requester wins the next tie.
REQ-022 A lone valid requester is granted in the same IDLE cycle regardless of the priority pointer.
REQ-023 In BUSY, data_addr/data_din/data_rd SHALL be stable; requester inputs are ignored.
REQ-024 In BUSY with complete_data=1: owner's rdata <= data_dout if data_rd=1 (rdata unchanged on writes); owner's done pulses the next cycle; data_req <= 0; pointer flips; state goes IDLE.
REQ-025 Minimum turnaround: accept at cycle T, data_req high T+1; complete_data at T+1 gives done at T+2, with a new accept possible in T+2.
REQ-026 In BUSY without complete_data, the counter increments; when it reaches TIMEOUT_CYCLES-1 it takes the same exit as REQ-024 but pulses err, not done, and rdata is unchanged.
REQ-027 If complete_data is asserted on the timeout cycle, the completion wins: done, not err.
REQ-028 complete_data in IDLE SHALL be ignored.
REQ-029 Counter width is 8 bits, saturating; TIMEOUT_CYCLES=0 is illegal (flagged by an assertion).

Reset
REQ-030 Reset SHALL force IDLE, data_req=0, data_addr=0, data_din=0, data_rd=0, done/err=0, rdata=0, counter=0, and pointer to req0 priority.
REQ-031 Reset asserted in BUSY SHALL abandon the transaction with no done or err pulse, and data_req SHALL be low in the next cycle.
REQ-032 While reset is high, both readies are 0.

Structure
REQ-033 Package dmem_arb_pkg SHALL hold the state enum (IDLE, BUSY), the owner ID type, and the TIMEOUT_CYCLES default constant.
REQ-034 The 2-way round-robin pick SHALL be the sub-module dmem_rr_pick: inputs valid[1:0] and pointer, output one-hot grant.

Verification
REQ-035 After reset, req0 read @0x3000 alone; memory returns 0xBEEF after 2 cycles -> ready0 at T, data_req T+1..T+2, done0 and rdata0=0xBEEF at T+3.
REQ-036 Both valid in the same cycle, twice back-to-back -> grants req0 then req1; data_addr/data_din match each owner.
REQ-037 req1 write 0x1234 to 0x4001 -> data_rd=0, data_din=0x1234 stable until complete; done1 pulses; rdata1 unchanged.
REQ-038 Memory never completes, TIMEOUT_CYCLES=32 -> err pulses exactly once 32 cycles after data_req rises; no done; FSM accepts the next request.
REQ-039 complete_data on the timeout cycle -> done, not err; complete_data in IDLE -> no pulse.
REQ-040 Reset mid-BUSY -> all outputs are reset values the next cycle; no done or err; the next tie goes to req0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Requester index: 0 = req0, 1 = req1.
  typedef logic owner_t;

  localparam owner_t OWNER_REQ0 = 1'b0;
  localparam owner_t OWNER_REQ1 = 1'b1;

  localparam logic [7:0] TIMEOUT_CYCLES_DEFAULT = 8'd32;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if;

  logic        req0_valid;
  logic        req0_rd;
  logic [15:0] req0_addr;
  logic [15:0] req0_wdata;
  logic        req0_ready;
  logic        req0_done;
  logic        req0_err;
  logic [15:0] req0_rdata;

  logic        req1_valid;
  logic        req1_rd;
  logic [15:0] req1_addr;
  logic [15:0] req1_wdata;
  logic        req1_ready;
  logic        req1_done;
  logic        req1_err;
  logic [15:0] req1_rdata;

  logic        data_req;
  logic [15:0] data_addr;
  logic [15:0] data_din;
  logic        data_rd;
  logic [15:0] data_dout;
  logic        complete_data;

  // The arbiter serves the requesters, so it takes the slave view.
  modport slave (
    input  req0_valid, req0_rd, req0_addr, req0_wdata,
    input  req1_valid, req1_rd, req1_addr, req1_wdata,
    input  data_dout, complete_data,
    output req0_ready, req0_done, req0_err, req0_rdata,
    output req1_ready, req1_done, req1_err, req1_rdata,
    output data_req, data_addr, data_din, data_rd
  );

  // Requesters plus the memory model.
  modport master (
    output req0_valid, req0_rd, req0_addr, req0_wdata,
    output req1_valid, req1_rd, req1_addr, req1_wdata,
    output data_dout, complete_data,
    input  req0_ready, req0_done, req0_err, req0_rdata,
    input  req1_ready, req1_done, req1_err, req1_rdata,
    input  data_req, data_addr, data_din, data_rd
  );

endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin pick: lone valid always wins, pointer breaks ties.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  owner_t     pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (pointer == OWNER_REQ1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one data-memory port, one transaction at a time,
// with a completion timeout.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input logic           clock,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [7:0] LAST_CNT = TIMEOUT_CYCLES - 8'd1;

  state_e            state_q, state_d;
  owner_t            owner_q, ptr_q;
  logic [7:0]        cnt_q;
  logic [15:0]       addr_q, din_q;
  logic              rd_q;
  logic [1:0]        done_q, err_q;
  logic [1:0][15:0]  rdata_q;

  logic [1:0]        valid, grant, ready;
  logic              accept, complete, timeout, finish, data_req;
  owner_t            acc_owner;
  logic [15:0]       sel_addr, sel_wdata;
  logic              sel_rd;

  assign valid = {bus.req1_valid, bus.req0_valid};

  dmem_rr_pick u_pick (
    .valid   (valid),
    .pointer (ptr_q),
    .grant   (grant)
  );

  assign accept    = |ready;
  assign acc_owner = ready[1];
  assign sel_addr  = acc_owner ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = acc_owner ? bus.req1_wdata : bus.req0_wdata;
  assign sel_rd    = acc_owner ? bus.req1_rd    : bus.req0_rd;

  // Completion outranks a timeout falling on the same cycle.
  assign complete = (state_q == BUSY) && bus.complete_data;
  assign timeout  = (state_q == BUSY) && !bus.complete_data && (cnt_q == LAST_CNT);
  assign finish   = complete || timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready    = 2'b00;
    data_req = 1'b0;
    case (state_q)
      IDLE:    if (!reset) ready = grant;
      BUSY:    data_req = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q <= OWNER_REQ0;
      ptr_q   <= OWNER_REQ0;
      cnt_q   <= 8'd0;
      addr_q  <= 16'd0;
      din_q   <= 16'd0;
      rd_q    <= 1'b0;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      rdata_q <= '0;
    end else begin
      done_q <= 2'b00;
      err_q  <= 2'b00;
      if (accept) begin
        owner_q <= acc_owner;
        addr_q  <= sel_addr;
        din_q   <= sel_wdata;
        rd_q    <= sel_rd;
        cnt_q   <= 8'd0;
      end else if (complete) begin
        done_q[owner_q] <= 1'b1;
        if (rd_q) rdata_q[owner_q] <= bus.data_dout;
        ptr_q <= ~owner_q;
      end else if (timeout) begin
        err_q[owner_q] <= 1'b1;
        ptr_q <= ~owner_q;
      end else if (state_q == BUSY) begin
        cnt_q <= sat_inc(cnt_q);
      end
    end
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.req0_done  = done_q[0];
  assign bus.req1_done  = done_q[1];
  assign bus.req0_err   = err_q[0];
  assign bus.req1_err   = err_q[1];
  assign bus.req0_rdata = rdata_q[0];
  assign bus.req1_rdata = rdata_q[1];
  assign bus.data_req   = data_req;
  assign bus.data_addr  = addr_q;
  assign bus.data_din   = din_q;
  assign bus.data_rd    = rd_q;

  // A zero timeout would make the counter compare against 8'hFF.
  timeout_nonzero_a: assert property (@(posedge clock) TIMEOUT_CYCLES != 8'd0);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed corner sequences, a grant table,
// and randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam logic [7:0] TMO = 8'd32;

  logic clock = 1'b0;
  logic reset;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at 1ms, required to finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.req0_valid = 0; bus.req0_rd = 0; bus.req0_addr = 0; bus.req0_wdata = 0;
    bus.req1_valid = 0; bus.req1_rd = 0; bus.req1_addr = 0; bus.req1_wdata = 0;
    bus.complete_data = 0; bus.data_dout = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle();
    next();
    next();
    reset = 0;
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic        rd;
    logic [15:0] dout;
    logic [1:0]  grant;
    logic [15:0] addr;
    logic [15:0] din;
  } vec_t;

  vec_t tbl [8];

  // Reference model state (transaction level).
  logic              m_busy;
  logic              m_owner;
  logic              m_pri;
  logic [15:0]       m_addr, m_din;
  logic              m_rd;
  int                m_n, m_lat;
  logic [1:0]        m_done, m_err;
  logic [15:0]       m_rdata [2];

  task automatic m_clear();
    m_busy = 0; m_owner = 0; m_pri = 0; m_addr = 0; m_din = 0; m_rd = 0;
    m_n = 0; m_lat = 0; m_done = 0; m_err = 0; m_rdata[0] = 0; m_rdata[1] = 0;
  endtask

  initial begin
    logic [1:0]  exp_rdy;
    logic [15:0] exp_rdata;
    idle();
    do_reset();

    // Single read after reset, memory answers after two BUSY cycles.
    bus.req0_valid = 1; bus.req0_rd = 1; bus.req0_addr = 16'h3000;
    #1;
    chk("r035_ready0_T", bus.req0_ready, 1);
    chk("r035_ready1_T", bus.req1_ready, 0);
    chk("r035_dreq_T", bus.data_req, 0);
    next(); idle(); #1;
    chk("r035_dreq_T1", bus.data_req, 1);
    chk("r035_addr_T1", bus.data_addr, 16'h3000);
    chk("r035_rd_T1", bus.data_rd, 1);
    next(); bus.complete_data = 1; bus.data_dout = 16'hBEEF; #1;
    chk("r035_dreq_T2", bus.data_req, 1);
    chk("r035_done_T2", bus.req0_done, 0);
    next(); idle(); #1;
    chk("r035_done_T3", bus.req0_done, 1);
    chk("r035_rdata_T3", bus.req0_rdata, 16'hBEEF);
    chk("r035_dreq_T3", bus.data_req, 0);
    next(); #1;
    chk("r035_done_T4", bus.req0_done, 0);

    // req1 write; requester inputs wiggle during BUSY and must be ignored.
    bus.req1_valid = 1; bus.req1_rd = 0; bus.req1_addr = 16'h4001; bus.req1_wdata = 16'h1234;
    #1;
    chk("r037_ready1", bus.req1_ready, 1);
    next();
    bus.req0_valid = 1; bus.req1_valid = 1; bus.req1_rd = 1;
    bus.req1_addr = 16'h0; bus.req1_wdata = 16'hFFFF;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk("r037_rd", bus.data_rd, 0);
      chk("r037_din", bus.data_din, 16'h1234);
      chk("r037_addr", bus.data_addr, 16'h4001);
      chk("r037_readies_busy", {bus.req1_ready, bus.req0_ready}, 2'b00);
      if (k == 3) begin bus.complete_data = 1; bus.data_dout = 16'h5A5A; end
      next();
    end
    idle(); #1;
    chk("r037_done1", bus.req1_done, 1);
    chk("r037_done0", bus.req0_done, 0);
    chk("r037_rdata1", bus.req1_rdata, 16'h0000);

    // Memory never answers: err exactly once, 32 cycles after data_req rises.
    bus.req0_valid = 1; bus.req0_rd = 1; bus.req0_addr = 16'h5555;
    #1;
    chk("r038_ready0", bus.req0_ready, 1);
    next(); idle();
    for (int k = 1; k <= 33; k++) begin
      #1;
      chk("r038_err0", bus.req0_err, (k == 33));
      chk("r038_done0", bus.req0_done, 0);
      chk("r038_dreq", bus.data_req, (k <= 32));
      if (k < 33) next();
    end
    chk("r038_rdata0", bus.req0_rdata, 16'hBEEF);
    bus.req1_valid = 1; bus.req1_addr = 16'h0042;
    #1;
    chk("r038_next_ready1", bus.req1_ready, 1);
    next(); idle(); bus.complete_data = 1; #1;
    chk("r038_next_addr", bus.data_addr, 16'h0042);
    next(); bus.complete_data = 0; #1;
    chk("r038_next_done1", bus.req1_done, 1);

    // Completion on the timeout cycle, then complete_data while IDLE.
    bus.req0_valid = 1; bus.req0_rd = 1; bus.req0_addr = 16'h6000;
    next(); idle();
    for (int k = 1; k <= 32; k++) begin
      if (k == 32) begin bus.complete_data = 1; bus.data_dout = 16'hC0DE; end
      next();
    end
    #1;
    chk("r039_done0", bus.req0_done, 1);
    chk("r039_err0", bus.req0_err, 0);
    chk("r039_rdata0", bus.req0_rdata, 16'hC0DE);
    for (int j = 0; j < 3; j++) begin
      next(); #1;
      chk("r039_idle_pulses", {bus.req1_err, bus.req0_err, bus.req1_done, bus.req0_done}, 0);
      chk("r039_idle_dreq", bus.data_req, 0);
    end
    bus.complete_data = 0;

    // Reset in the middle of BUSY.
    bus.req1_valid = 1; bus.req1_rd = 0; bus.req1_addr = 16'h7777; bus.req1_wdata = 16'h9999;
    next(); idle(); #1;
    chk("r040_dreq_busy", bus.data_req, 1);
    reset = 1; bus.complete_data = 1; bus.data_dout = 16'h1111;
    bus.req0_valid = 1; bus.req1_valid = 1;
    next(); #1;
    chk("r040_dreq", bus.data_req, 0);
    chk("r040_addr", bus.data_addr, 0);
    chk("r040_din", bus.data_din, 0);
    chk("r040_rd", bus.data_rd, 0);
    chk("r040_pulses", {bus.req1_err, bus.req0_err, bus.req1_done, bus.req0_done}, 0);
    chk("r040_rdata0", bus.req0_rdata, 0);
    chk("r040_rdata1", bus.req1_rdata, 0);
    chk("r040_readies_in_reset", {bus.req1_ready, bus.req0_ready}, 2'b00);
    reset = 0; bus.complete_data = 0; #1;
    chk("r040_tie_after_reset", {bus.req1_ready, bus.req0_ready}, 2'b01);
    next(); idle(); bus.complete_data = 1;
    next(); bus.complete_data = 0;

    // Grant table; each row completes after one BUSY cycle, next row accepted in the done cycle.
    tbl[0] = '{2'b11, 1'b1, 16'h0101, 2'b01, 16'h1000, 16'hA000};
    tbl[1] = '{2'b11, 1'b0, 16'h0000, 2'b10, 16'h2001, 16'hB001};
    tbl[2] = '{2'b10, 1'b1, 16'h0202, 2'b10, 16'h2002, 16'hB002};
    tbl[3] = '{2'b11, 1'b1, 16'h0303, 2'b01, 16'h1003, 16'hA003};
    tbl[4] = '{2'b01, 1'b0, 16'h0404, 2'b01, 16'h1004, 16'hA004};
    tbl[5] = '{2'b11, 1'b1, 16'h0505, 2'b10, 16'h2005, 16'hB005};
    tbl[6] = '{2'b00, 1'b1, 16'h0000, 2'b00, 16'h0000, 16'h0000};
    tbl[7] = '{2'b11, 1'b1, 16'h0707, 2'b01, 16'h1007, 16'hA007};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.req0_valid = tbl[i].valid[0]; bus.req1_valid = tbl[i].valid[1];
      bus.req0_rd = tbl[i].rd; bus.req1_rd = tbl[i].rd;
      bus.req0_addr = 16'h1000 + 16'(i); bus.req0_wdata = 16'hA000 + 16'(i);
      bus.req1_addr = 16'h2000 + 16'(i); bus.req1_wdata = 16'hB000 + 16'(i);
      #1;
      chk($sformatf("tbl%0d_grant", i), {bus.req1_ready, bus.req0_ready}, tbl[i].grant);
      if (tbl[i].grant != 2'b00) begin
        next(); idle(); #1;
        chk($sformatf("tbl%0d_addr", i), bus.data_addr, tbl[i].addr);
        chk($sformatf("tbl%0d_din", i), bus.data_din, tbl[i].din);
        chk($sformatf("tbl%0d_rd", i), bus.data_rd, tbl[i].rd);
        bus.complete_data = 1; bus.data_dout = tbl[i].dout;
        next(); bus.complete_data = 0; #1;
        chk($sformatf("tbl%0d_done", i), {bus.req1_done, bus.req0_done}, tbl[i].grant);
        if (tbl[i].rd) begin
          exp_rdata = tbl[i].grant[1] ? bus.req1_rdata : bus.req0_rdata;
          chk($sformatf("tbl%0d_rdata", i), exp_rdata, tbl[i].dout);
        end
      end else begin
        next(); idle();
      end
    end

    // Randomized traffic against the reference model.
    do_reset();
    m_clear();
    for (int c = 0; c < 2000; c++) begin
      bus.req0_valid = 1'($urandom); bus.req1_valid = 1'($urandom);
      bus.req0_rd = 1'($urandom); bus.req1_rd = 1'($urandom);
      bus.req0_addr = 16'($urandom); bus.req1_addr = 16'($urandom);
      bus.req0_wdata = 16'($urandom); bus.req1_wdata = 16'($urandom);
      bus.data_dout = 16'($urandom);
      reset = ($urandom_range(0, 127) == 0);
      bus.complete_data = m_busy ? (m_n == m_lat) : ($urandom_range(0, 2) == 0);
      #1;
      exp_rdy = 2'b00;
      if (!reset && !m_busy) begin
        if (bus.req0_valid && bus.req1_valid) exp_rdy = m_pri ? 2'b10 : 2'b01;
        else exp_rdy = {bus.req1_valid, bus.req0_valid};
      end
      chk("rnd_ctl", {bus.req1_ready, bus.req0_ready, bus.data_req, bus.data_rd,
                      bus.req1_done, bus.req0_done, bus.req1_err, bus.req0_err},
          {exp_rdy, m_busy, m_rd, m_done, m_err});
      chk("rnd_addr", bus.data_addr, m_addr);
      chk("rnd_din", bus.data_din, m_din);
      chk("rnd_rdata0", bus.req0_rdata, m_rdata[0]);
      chk("rnd_rdata1", bus.req1_rdata, m_rdata[1]);
      if (reset) begin
        m_clear();
      end else begin
        m_done = 0; m_err = 0;
        if (!m_busy) begin
          if (exp_rdy != 2'b00) begin
            m_owner = exp_rdy[1];
            m_addr  = m_owner ? bus.req1_addr : bus.req0_addr;
            m_din   = m_owner ? bus.req1_wdata : bus.req0_wdata;
            m_rd    = m_owner ? bus.req1_rd : bus.req0_rd;
            m_busy  = 1; m_n = 0;
            m_lat   = ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 4));
          end
        end else if (bus.complete_data) begin
          m_done[m_owner] = 1;
          if (m_rd) m_rdata[m_owner] = bus.data_dout;
          m_busy = 0; m_pri = !m_owner;
        end else if (m_n == int'(TMO) - 1) begin
          m_err[m_owner] = 1;
          m_busy = 0; m_pri = !m_owner;
        end else begin
          m_n++;
        end
      end
      next();
    end
    reset = 0;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
